// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FREEZE   = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO      = 5'd0;
    localparam logic [31:0] NOP_INSTR     = 32'h0;
    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/fetch_hazard_controller_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
import pipe_ctrl_pkg::*;

module sat_counter #(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/fetch_hazard_controller.sv
// Fetch-stage stall/branch sequencing with load-use detection, external
// freeze handling and saturating stall/flush performance counters.
import pipe_ctrl_pkg::*;

module fetch_hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ext_stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic             stall,
    output logic             is_branch,
    output logic [31:0]      pc_final,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             hold_ex,
    output logic             target_misaligned,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [1:0]       state_o
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       hz;
    logic       run_eval;

    assign hz = ex_mem_read && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign pc_final          = {branch_target[31:2], 2'b00};
    assign target_misaligned = is_branch && (branch_target[1:0] != 2'b00);
    assign state_o           = state;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stall     = 1'b0;
        is_branch = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        hold_ex   = 1'b0;
        run_eval  = 1'b0;

        if (!reset) begin
            case (state)
                RUN:    run_eval = 1'b1;
                FREEZE: begin
                    if (ext_stall) begin
                        stall   = 1'b1;
                        hold_ex = 1'b1;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                BR_FLUSH: begin
                    flush_id = 1'b1;
                    if (ext_stall) begin
                        stall   = 1'b1;
                        hold_ex = 1'b1;
                    end else begin
                        cnt_n = cnt - 3'd1;
                        if (cnt == 3'd1)
                            state_n = RUN;
                    end
                end
                default: state_n = RUN;
            endcase

            // FREEZE release shares the RUN decision so a branch arriving on
            // the release cycle still enters its flush window.
            if (run_eval) begin
                state_n = RUN;
                if (branch_taken) begin
                    is_branch = 1'b1;
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_n = BR_FLUSH;
                        cnt_n   = FLUSH_RELOAD;
                    end
                end else if (hz) begin
                    stall     = 1'b1;
                    bubble_ex = 1'b1;
                end else if (ext_stall) begin
                    stall   = 1'b1;
                    hold_ex = 1'b1;
                    state_n = FREEZE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (is_branch),
        .count (flush_events)
    );

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed scoreboard bench for fetch_hazard_controller (FLUSH_CYCLES=3).
module tb_fetch_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ext_stall, branch_taken;
    logic [31:0] branch_target;
    logic        stall, is_branch, flush_id, bubble_ex, hold_ex, target_misaligned;
    logic [31:0] pc_final;
    logic [15:0] stall_cycles, flush_events;
    logic [1:0]  state_o;

    always #5 clk = ~clk;

    fetch_hazard_controller #(.FLUSH_CYCLES(3), .CNT_W(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_uses_rt        (id_uses_rt),
        .ex_mem_read       (ex_mem_read),
        .ex_rt             (ex_rt),
        .ext_stall         (ext_stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .stall             (stall),
        .is_branch         (is_branch),
        .pc_final          (pc_final),
        .flush_id          (flush_id),
        .bubble_ex         (bubble_ex),
        .hold_ex           (hold_ex),
        .target_misaligned (target_misaligned),
        .stall_cycles      (stall_cycles),
        .flush_events      (flush_events),
        .state_o           (state_o)
    );

    typedef struct packed {
        logic        stall, is_branch, flush_id, bubble_ex, hold_ex, mis;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [15:0] sc, fe;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [15:0] m_sc = '0;
    logic [15:0] m_fe = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic br, input logic [31:0] tgt,
                         input logic rd, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ur, input logic ext);
        reset = rst; branch_taken = br; branch_target = tgt; ex_mem_read = rd;
        ex_rt = xrt; id_rs = rs; id_rt = rt; id_uses_rt = ur; ext_stall = ext;
    endtask

    // Push expectation for the current cycle, then advance the counter model.
    task automatic step(input string tag, input logic st, input logic ib, input logic fl,
                        input logic bb, input logic hd, input logic [1:0] s);
        exp_t e;
        e.stall = st; e.is_branch = ib; e.flush_id = fl; e.bubble_ex = bb; e.hold_ex = hd;
        e.mis = ib && (branch_target[1:0] != 2'b00);
        e.pc  = {branch_target[31:2], 2'b00};
        e.st  = s; e.sc = m_sc; e.fe = m_fe;
        sb.push_back(e);
        if (st && m_sc != 16'hFFFF) m_sc++;
        if (ib && m_fe != 16'hFFFF) m_fe++;
        if (reset) begin m_sc = '0; m_fe = '0; end

        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s.scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".stall"},     {31'd0, stall},             {31'd0, e.stall});
            chk({tag, ".is_branch"}, {31'd0, is_branch},         {31'd0, e.is_branch});
            chk({tag, ".flush_id"},  {31'd0, flush_id},          {31'd0, e.flush_id});
            chk({tag, ".bubble_ex"}, {31'd0, bubble_ex},         {31'd0, e.bubble_ex});
            chk({tag, ".hold_ex"},   {31'd0, hold_ex},           {31'd0, e.hold_ex});
            chk({tag, ".misalign"},  {31'd0, target_misaligned}, {31'd0, e.mis});
            chk({tag, ".pc_final"},  pc_final,                   e.pc);
            chk({tag, ".state"},     {30'd0, state_o},           {30'd0, e.st});
            chk({tag, ".stall_cyc"}, {16'd0, stall_cycles},      {16'd0, e.sc});
            chk({tag, ".flush_ev"},  {16'd0, flush_events},      {16'd0, e.fe});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every request active: outputs must still be 0.
        drive(1, 1, 32'h10, 1, 5'd8, 5'd8, 5'd0, 0, 1);
        @(posedge clk); #1;
        step("reset",      0, 0, 0, 0, 0, 2'd0);

        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("idle",       0, 0, 0, 0, 0, 2'd0);

        drive(0, 0, 32'h0, 1, 5'd8, 5'd8, 5'd0, 0, 0);
        step("lu_rs",      1, 0, 0, 1, 0, 2'd0);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd8, 5'd0, 0, 0);
        step("lu_after",   0, 0, 0, 0, 0, 2'd0);

        drive(0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
        step("lu_zero",    0, 0, 0, 0, 0, 2'd0);
        drive(0, 0, 32'h0, 1, 5'd9, 5'd3, 5'd9, 1, 0);
        step("lu_rt",      1, 0, 0, 1, 0, 2'd0);
        drive(0, 0, 32'h0, 1, 5'd9, 5'd3, 5'd9, 0, 0);
        step("lu_rt_off",  0, 0, 0, 0, 0, 2'd0);

        // Branch wins over a simultaneous hazard and ext_stall.
        drive(0, 1, 32'h0000_0010, 1, 5'd8, 5'd8, 5'd0, 0, 1);
        step("br_hz",      0, 1, 1, 1, 0, 2'd0);
        drive(0, 1, 32'h0000_0040, 1, 5'd8, 5'd8, 5'd0, 0, 0);
        step("flush1",     0, 0, 1, 0, 0, 2'd2);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("flush2",     0, 0, 1, 0, 0, 2'd2);
        step("flush_done", 0, 0, 0, 0, 0, 2'd0);

        // Misaligned target, then an ext_stall freezing the flush count.
        drive(0, 1, 32'h0000_1237, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("br_mis",     0, 1, 1, 1, 0, 2'd0);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("fl_ext",     1, 0, 1, 0, 1, 2'd2);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("fl_res1",    0, 0, 1, 0, 0, 2'd2);
        step("fl_res2",    0, 0, 1, 0, 0, 2'd2);
        step("fl_end",     0, 0, 0, 0, 0, 2'd0);

        // ext_stall held for 4 cycles.
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("ext1",       1, 0, 0, 0, 1, 2'd0);
        step("ext2",       1, 0, 0, 0, 1, 2'd1);
        step("ext3",       1, 0, 0, 0, 1, 2'd1);
        step("ext4",       1, 0, 0, 0, 1, 2'd1);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("ext_rel",    0, 0, 0, 0, 0, 2'd1);
        step("ext_run",    0, 0, 0, 0, 0, 2'd0);

        // Branch ignored while frozen.
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("fz_in",      1, 0, 0, 0, 1, 2'd0);
        drive(0, 1, 32'h0000_0080, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        step("fz_br",      1, 0, 0, 0, 1, 2'd1);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("fz_rel",     0, 0, 0, 0, 0, 2'd1);

        // Hazard has priority over ext_stall and does not freeze.
        drive(0, 0, 32'h0, 1, 5'd4, 5'd4, 5'd0, 0, 1);
        step("hz_ext",     1, 0, 0, 1, 0, 2'd0);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("hz_ext_run", 0, 0, 0, 0, 0, 2'd0);

        // Saturate the stall counter.
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        repeat (65540) @(posedge clk);
        #1;
        m_sc = 16'hFFFF;
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("sat_rel",    0, 0, 0, 0, 0, 2'd1);
        drive(0, 0, 32'h0, 1, 5'd7, 5'd7, 5'd0, 0, 0);
        step("sat_hz",     1, 0, 0, 1, 0, 2'd0);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("sat_hold",   0, 0, 0, 0, 0, 2'd0);

        // Reset in the middle of a flush window.
        drive(0, 1, 32'h0000_0100, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("rb_br",      0, 1, 1, 1, 0, 2'd0);
        drive(1, 1, 32'h0000_0200, 1, 5'd8, 5'd8, 5'd0, 0, 1);
        step("rb_reset",   0, 0, 0, 0, 0, 2'd2);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step("rb_after",   0, 0, 0, 0, 0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_controller.md
Name: fetch_hazard_controller

Overview:
- Sequences the instruction-fetch stage and the IF/ID and ID/EX pipeline registers of the 5-stage MIPS pipeline.
- Detects load-use hazards, resolves taken branches/jumps coming from EX, and absorbs external multi-cycle stall requests.
- Produces the fetch stage's Stall, Is_Branch and PC_Final controls plus flush/bubble strobes for the downstream pipeline registers.
- Keeps saturating performance counters for stall cycles and branch flushes.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed after a taken branch (1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- ext_stall  in  1  external freeze request (e.g. multi-cycle ALU op)
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- branch_target  in  32  target PC from EX
- stall  out  1  to fetch Stall; holds PC and IF/ID
- is_branch  out  1  to fetch Is_Branch
- pc_final  out  32  to fetch PC_Final
- flush_id  out  1  clear IF/ID to NOP
- bubble_ex  out  1  load NOP control into ID/EX
- hold_ex  out  1  freeze ID/EX and EX/MEM
- target_misaligned  out  1  one-cycle pulse when branch_target[1:0]!=0
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1
- flush_events  out  CNT_W  saturating count of accepted taken branches
- state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=RUN, flush counter=0, both perf counters=0.
  - All control outputs are forced 0 while reset=1, regardless of inputs.
  - Reset asserted mid-flush aborts the flush; the next cycle after deassert is RUN.
- Control outputs are combinational from state and current inputs; state and counters update on the rising clk edge.
- Hazard definition: hz = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- pc_final = {branch_target[31:2],2'b00} always. target_misaligned = is_branch && branch_target[1:0]!=0.
- State RUN, priority branch > hazard > ext_stall:
  - branch_taken: is_branch=1, flush_id=1, bubble_ex=1, stall=0, flush_events++.
    - If FLUSH_CYCLES>1, go to BR_FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
    - A simultaneous hazard or ext_stall is discarded, since that ID instruction is wrong-path.
  - hz: stall=1, bubble_ex=1, hold_ex=0. Stay in RUN. The stall lasts exactly 1 cycle because the load leaves EX.
  - ext_stall (no hz): stall=1, hold_ex=1, bubble_ex=0, go to FREEZE.
  - Otherwise all outputs are 0.
- State FREEZE:
  - stall=1, hold_ex=1 while ext_stall=1.
  - When ext_stall=0: outputs as RUN with the same cycle's inputs, and next state = RUN.
  - branch_taken is ignored while ext_stall=1 because EX is frozen.
- State BR_FLUSH:
  - flush_id=1, stall=0, cnt--. Return to RUN when cnt==1.
  - branch_taken and hz are ignored (wrong-path instructions).
  - ext_stall freezes cnt and asserts stall=1, hold_ex=1.
- Counters:
  - stall_cycles += 1 on each cycle with stall=1.
  - flush_events += 1 on each accepted branch.
  - Both saturate at all-ones and never wrap.
- State encoding: RUN=0, FREEZE=1, BR_FLUSH=2. Encoding 3 is illegal and recovers to RUN on the next clock.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN/FREEZE/BR_FLUSH);
  - REG_ZERO=5'd0, NOP_INSTR=32'h0;
  - the counter-width default.
- Natural sub-module sat_counter (CNT_W, inc, reset), instantiated twice.
- Hazard compare and FSM stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> stall=1, bubble_ex=1 for exactly 1 cycle; stall_cycles=1.
- Load to $zero: ex_mem_read=1, ex_rt=0, id_rs=0 -> stall=0, bubble_ex=0.
- Branch plus hazard in the same cycle: branch_taken=1, target=32'h0000_0010, hz=1 -> is_branch=1, pc_final=32'h10, flush_id=1, stall=0; flush_events=1.
- FLUSH_CYCLES=3 branch:
  - flush_id=1 on 3 consecutive cycles, with state_o reading 0,2,2 across them;
  - a second branch_taken in cycle 2 is ignored, flush_events stays 1.
- ext_stall held for 4 cycles, then drops -> stall=1 and hold_ex=1 for 4 cycles; stall_cycles=4; RUN on the 5th cycle.
- Saturation and reset:
  - preload via 65540 stall cycles -> stall_cycles=16'hFFFF;
  - reset mid-BR_FLUSH -> all outputs 0 and counters 0 the next cycle.
